dmem_responder: RTL and testbench

- Data-memory responder serving the core's load/store port over a valid/ready request/response handshake.
- Holds a word-organised RAM and performs byte/half/word stores with lane selection, plus sign/zero-extended loads decoded from RV32I funct3.
- Inserts a configurable number of wait states.
- Flags misaligned, out-of-range and illegal-size accesses.

---
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store port onto a word-organised RAM,
// with RV32I size/sign decoding, programmable wait states and fault flagging.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_resp_valid;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_lane;
    logic                  w_out_of_range;
    logic                  w_err;
    logic                  w_access;
    logic                  w_wr_en;
    logic [3:0]            w_be;
    logic [31:0]           w_wr_data;
    logic [31:0]           w_rd_word;
    logic [31:0]           w_shift;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_data;

    assign w_idx          = r_addr[ADDR_WIDTH+1:2];
    assign w_lane         = r_addr[1:0];
    assign w_out_of_range = (r_addr >> (ADDR_WIDTH + 2)) != 32'd0;

    assign w_err = w_out_of_range
                || (((r_funct3 == 3'b001) || (r_funct3 == 3'b101)) && r_addr[0])
                || ((r_funct3 == 3'b010) && (w_lane != 2'b00))
                || (r_funct3 == 3'b011) || (r_funct3 == 3'b110) || (r_funct3 == 3'b111)
                || (r_we && r_funct3[2]);

    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_wr_en  = w_access && r_we && !w_err;

    // Store data is replicated across lanes so each lane just picks its own byte.
    always_comb begin
        w_be      = 4'b1111;
        w_wr_data = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be      = 4'b0001 << w_lane;
                w_wr_data = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be      = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wr_data = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be      = 4'b1111;
                w_wr_data = r_wdata;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (w_wr_en && w_be[gi]) begin
                    r_mem[w_idx] <= w_wr_data[8*gi +: 8];
                end
            end

            assign w_rd_word[8*gi +: 8] = r_mem[w_idx];
        end
    endgenerate

    assign w_shift = w_rd_word >> {w_lane, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    always_comb begin
        w_load_data = 32'd0;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = w_rd_word;
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_funct3     <= 3'd0;
            r_resp_valid <= 1'b0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_funct3 <= req_funct3;
                        r_cnt    <= 4'(WAIT_CYCLES);
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_err        <= w_err;
                        r_rdata      <= (w_err || r_we) ? 32'd0 : w_load_data;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a byte-addressed reference memory,
// with directed loads/stores, faults, backpressure and mid-transaction reset.
module tb_dmem_responder;

    localparam int AW          = 10;
    localparam int WAIT_CYCLES = 1;
    localparam int BYTES       = 4 * (2 ** AW);

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference memory: one entry per byte ever written.
    logic [7:0] ref_mem [int unsigned];

    function automatic void ref_access(input bit we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [2:0] f3,
                                       output logic [31:0] rdata, output bit err,
                                       output bit known);
        int size;
        rdata = 32'd0;
        known = 1'b1;
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        err = (addr >= 32'(BYTES)) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7)
           || (we && f3 >= 3'd4);
        if (!err && (addr % size) != 0) err = 1'b1;
        if (err) return;
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++) begin
                if (!ref_mem.exists(addr + i)) known = 1'b0;
                else rdata = rdata | (32'(ref_mem[addr + i]) << (8 * i));
            end
            if (f3 < 3'd4 && size < 4 && rdata[8*size-1]) rdata = rdata | (32'hFFFF_FFFF << (8 * size));
        end
    endfunction

    logic [31:0] last_rdata;
    logic        last_err;

    task automatic do_txn(input string tag, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input int bp, input bit pulse);
        logic [31:0] exp_r;
        bit          exp_e;
        bit          known;
        int          lat;
        ref_access(we, addr, wdata, f3, exp_r, exp_e, known);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        check_eq({tag, "/ready_idle"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            lat++;
            @(posedge clk);
            #1;
        end
        check_eq({tag, "/latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
        last_rdata = resp_rdata;
        last_err   = resp_err;
        check_eq({tag, "/err"}, 32'(resp_err), 32'(exp_e));
        if (known) check_eq({tag, "/rdata"}, resp_rdata, exp_r);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (pulse && i == 1) begin
                req_valid  = 1'b1;
                req_we     = 1'b1;
                req_addr   = 32'h10;
                req_wdata  = 32'hBAD0_BAD0;
                req_funct3 = 3'b010;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check_eq({tag, "/hold_flags"}, {29'd0, resp_valid, req_ready, resp_err},
                     {29'd0, 1'b1, 1'b0, last_err});
            check_eq({tag, "/hold_rdata"}, resp_rdata, last_rdata);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "/release"}, {30'd0, resp_valid, req_ready}, 32'b01);
        resp_ready = 1'b0;
        $display("txn %s we=%0d addr=%08h f3=%0d rdata=%08h err=%0d lat=%0d",
                 tag, we, addr, f3, last_rdata, last_err, lat);
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_funct3 = 3'd0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset/flags", {29'd0, resp_valid, resp_err, req_ready}, 32'b001);
        check_eq("reset/rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Known contents for the first 16 words; word 0x20 starts at zero.
        for (int w = 0; w < 16; w++)
            do_txn("init", 1'b1, 32'(4 * w), (w == 8) ? 32'd0 : $urandom, 3'b010, 0, 1'b0);

        do_txn("sw10", 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 0, 1'b0);
        do_txn("lw10", 1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0);
        check_eq("plan/lw10", last_rdata, 32'hDEAD_BEEF);
        do_txn("sb11", 1'b1, 32'h11, 32'h12, 3'b000, 0, 1'b0);
        do_txn("lw10b", 1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0);
        check_eq("plan/lw10b", last_rdata, 32'hDEAD_12EF);
        do_txn("lb13", 1'b0, 32'h13, 32'h0, 3'b000, 0, 1'b0);
        check_eq("plan/lb13", last_rdata, 32'hFFFF_FFDE);
        do_txn("lbu13", 1'b0, 32'h13, 32'h0, 3'b100, 0, 1'b0);
        check_eq("plan/lbu13", last_rdata, 32'h0000_00DE);
        do_txn("lh12", 1'b0, 32'h12, 32'h0, 3'b001, 0, 1'b0);
        check_eq("plan/lh12", last_rdata, 32'hFFFF_DEAD);
        do_txn("lhu10", 1'b0, 32'h10, 32'h0, 3'b101, 0, 1'b0);
        check_eq("plan/lhu10", last_rdata, 32'h0000_12EF);

        do_txn("lh11", 1'b0, 32'h11, 32'h0, 3'b001, 0, 1'b0);
        check_eq("plan/lh11", {last_rdata[30:0], last_err}, 32'd1);
        do_txn("sw12", 1'b1, 32'h12, 32'hCAFE_F00D, 3'b010, 0, 1'b0);
        check_eq("plan/sw12_err", 32'(last_err), 32'd1);
        do_txn("sbu", 1'b1, 32'h10, 32'h55, 3'b100, 0, 1'b0);
        do_txn("lw10c", 1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0);
        check_eq("plan/lw10c", last_rdata, 32'hDEAD_12EF);
        do_txn("f3_011", 1'b0, 32'h10, 32'h0, 3'b011, 0, 1'b0);
        check_eq("plan/f3_011", 32'(last_err), 32'd1);
        do_txn("oor", 1'b0, 32'h1000, 32'h0, 3'b010, 0, 1'b0);
        check_eq("plan/oor", 32'(last_err), 32'd1);
        do_txn("top", 1'b0, 32'hFFC, 32'h0, 3'b010, 0, 1'b0);

        do_txn("bp", 1'b0, 32'h10, 32'h0, 3'b010, 5, 1'b1);
        do_txn("bp_after", 1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0);
        check_eq("plan/bp_ignored", last_rdata, 32'hDEAD_12EF);

        // Reset while the store to 0x20 is still waiting for its access edge.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'h1111_1111;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b0;
        #2;
        check_eq("rst_mid/flags", {30'd0, resp_valid, req_ready}, 32'b01);
        @(negedge clk);
        rst = 1'b1;
        do_txn("lw20", 1'b0, 32'h20, 32'h0, 3'b010, 0, 1'b0);
        check_eq("plan/lw20", last_rdata, 32'h0);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 63));
            do_txn("rand", 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
